// File: rtl/worley_pkg.sv
// Shared types and reset tables for the Worley feature-point sequencer.
package worley_pkg;

   typedef enum logic [1:0] {StIdle, StStep, StCommit, StDone} state_e;

   localparam int unsigned MAX_POINTS = 8;

   // Entries past NUM_POINTS are ignored by the sequencer.
   localparam int unsigned INIT_X  [MAX_POINTS] = '{100, 300, 500, 100, 50, 250, 450, 600};
   localparam int unsigned INIT_Y  [MAX_POINTS] = '{100, 200, 400, 450, 300, 50, 250, 350};
   localparam int unsigned INIT_VX [MAX_POINTS] = '{3, 2, 1, 4, 2, 3, 1, 5};
   localparam int unsigned INIT_VY [MAX_POINTS] = '{1, 2, 3, 2, 4, 1, 2, 3};

   localparam logic [7:0] LFSR_INIT = 8'hA5;

endpackage

// File: rtl/worley_point_sequencer_if.sv
// Control/status and point-set bus between the noise datapath and the point sequencer.
interface worley_point_sequencer_if #(
   parameter int unsigned NUM_POINTS = 4,
   parameter int unsigned COORD_W    = 10
);
   logic                          frame_start;
   logic                          pause;
   logic [1:0]                    speed;
   logic [NUM_POINTS*COORD_W-1:0] pt_x;
   logic [NUM_POINTS*COORD_W-1:0] pt_y;
   logic                          busy;
   logic                          done;
   logic                          overrun;

   modport master (
      output frame_start, pause, speed,
      input  pt_x, pt_y, busy, done, overrun
   );

   modport slave (
      input  frame_start, pause, speed,
      output pt_x, pt_y, busy, done, overrun
   );
endinterface

// File: rtl/worley_axis_step.sv
// Combinational single-axis step with reflection off 0 and max_coord.
module worley_axis_step #(
   parameter int unsigned COORD_W = 10,
   parameter int unsigned VEL_W   = 4
) (
   input  logic [COORD_W-1:0] p,
   input  logic               dir,
   input  logic [VEL_W-1:0]   mag,
   input  logic [1:0]         speed,
   input  logic [COORD_W-1:0] max_coord,
   output logic [COORD_W-1:0] new_p,
   output logic               new_dir,
   output logic               bounced
);
   localparam int unsigned W1 = COORD_W + 1;

   logic [W1-1:0] raw_step;
   logic [W1-1:0] step;
   logic [W1-1:0] sum;
   logic [W1-1:0] refl;

   // Step is clamped to max_coord, so sum <= 2*max_coord and every branch stays in range.
   always_comb begin
      raw_step = W1'(mag) << speed;
      step     = (raw_step > {1'b0, max_coord}) ? {1'b0, max_coord} : raw_step;
      sum      = {1'b0, p} + step;
      refl     = {max_coord, 1'b0} - sum;
      new_p    = p;
      new_dir  = dir;
      bounced  = 1'b0;
      if (dir) begin
         if (sum <= {1'b0, max_coord}) begin
            new_p = sum[COORD_W-1:0];
         end else begin
            new_p   = refl[COORD_W-1:0];
            new_dir = 1'b0;
            bounced = 1'b1;
         end
      end else begin
         if (step <= {1'b0, p}) begin
            new_p = p - step[COORD_W-1:0];
         end else begin
            new_p   = step[COORD_W-1:0] - p;
            new_dir = 1'b1;
            bounced = 1'b1;
         end
      end
   end
endmodule

// File: rtl/worley_point_sequencer.sv
// Steps Worley feature points once per frame through a shadow file, then commits atomically.
// Optional magnitude jitter on bounce is enabled by defining WORLEY_JITTER_EN.
module worley_point_sequencer
   import worley_pkg::*;
#(
   parameter int unsigned NUM_POINTS = 4,
   parameter int unsigned COORD_W    = 10,
   parameter int unsigned X_MAX      = 639,
   parameter int unsigned Y_MAX      = 479,
   parameter int unsigned VEL_W      = 4
) (
   input logic                     clk,
   input logic                     rst_n,
   worley_point_sequencer_if.slave bus
);
   localparam int unsigned IDX_W = $clog2(NUM_POINTS);

   state_e                             state_q;
   logic [IDX_W-1:0]                   idx_q;
   logic [NUM_POINTS-1:0][COORD_W-1:0] act_x_q, act_y_q, sh_x_q, sh_y_q;
   logic [NUM_POINTS-1:0]              dir_x_q, dir_y_q;
   logic [NUM_POINTS-1:0][VEL_W-1:0]   mag_x_q, mag_y_q;
   logic                               busy_q, done_q, overrun_q;

   logic [COORD_W-1:0] nx, ny;
   logic               ndx, ndy, bx, by;

   worley_axis_step #(.COORD_W(COORD_W), .VEL_W(VEL_W)) u_step_x (
      .p         (sh_x_q[idx_q]),
      .dir       (dir_x_q[idx_q]),
      .mag       (mag_x_q[idx_q]),
      .speed     (bus.speed),
      .max_coord (COORD_W'(X_MAX)),
      .new_p     (nx),
      .new_dir   (ndx),
      .bounced   (bx)
   );

   worley_axis_step #(.COORD_W(COORD_W), .VEL_W(VEL_W)) u_step_y (
      .p         (sh_y_q[idx_q]),
      .dir       (dir_y_q[idx_q]),
      .mag       (mag_y_q[idx_q]),
      .speed     (bus.speed),
      .max_coord (COORD_W'(Y_MAX)),
      .new_p     (ny),
      .new_dir   (ndy),
      .bounced   (by)
   );

`ifdef WORLEY_JITTER_EN
   logic [7:0]       lfsr_q;
   logic [VEL_W-1:0] jit_mag;

   always_ff @(posedge clk) begin
      if (!rst_n) lfsr_q <= LFSR_INIT;
      else        lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end

   assign jit_mag = VEL_W'(lfsr_q[2:0] | 3'd1);
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
         dir_x_q   <= '1;
         dir_y_q   <= '1;
         for (int i = 0; i < NUM_POINTS; i++) begin
            act_x_q[i] <= COORD_W'(INIT_X[i]);
            act_y_q[i] <= COORD_W'(INIT_Y[i]);
            sh_x_q[i]  <= COORD_W'(INIT_X[i]);
            sh_y_q[i]  <= COORD_W'(INIT_Y[i]);
            mag_x_q[i] <= VEL_W'(INIT_VX[i]);
            mag_y_q[i] <= VEL_W'(INIT_VY[i]);
         end
      end else begin
         done_q <= 1'b0;
         if (bus.frame_start && busy_q) overrun_q <= 1'b1;
         case (state_q)
            StIdle: begin
               if (bus.frame_start) begin
                  state_q <= StStep;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            StStep: begin
               if (!bus.pause) begin
                  sh_x_q[idx_q]  <= nx;
                  sh_y_q[idx_q]  <= ny;
                  dir_x_q[idx_q] <= ndx;
                  dir_y_q[idx_q] <= ndy;
`ifdef WORLEY_JITTER_EN
                  if (bx) mag_x_q[idx_q] <= jit_mag;
                  if (by) mag_y_q[idx_q] <= jit_mag;
`endif
               end
               if (idx_q == IDX_W'(NUM_POINTS - 1)) state_q <= StCommit;
               else                                 idx_q   <= idx_q + IDX_W'(1);
            end
            StCommit: begin
               act_x_q <= sh_x_q;
               act_y_q <= sh_y_q;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= StDone;
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

`ifndef WORLEY_JITTER_EN
   logic unused_bounce;
   assign unused_bounce = bx ^ by;
`endif

   assign bus.pt_x    = act_x_q;
   assign bus.pt_y    = act_y_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_worley_point_sequencer.sv
// Randomized scoreboard bench for worley_point_sequencer against an integer reflect model.
module tb_worley_point_sequencer;
   import worley_pkg::*;

   localparam int N  = 4;
   localparam int CW = 10;
   localparam int XM = 639;
   localparam int YM = 479;

   typedef logic [N*CW-1:0] flat_t;
   typedef struct {
      flat_t x;
      flat_t y;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   worley_point_sequencer_if #(.NUM_POINTS(N), .COORD_W(CW)) bus ();

   worley_point_sequencer #(
      .NUM_POINTS (N),
      .COORD_W    (CW),
      .X_MAX      (XM),
      .Y_MAX      (YM),
      .VEL_W      (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];
   exp_t mon_e;
   int   mx[N], my[N], dx[N], dy[N];
   bit   ovr_exp;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reflect rule on plain integers.
   function automatic void axis(inout int p, inout int d, input int mag, input int spd,
                                input int lim);
      int s;
      s = mag << spd;
      if (s > lim) s = lim;
      if (d > 0) begin
         if (p + s <= lim) p = p + s;
         else begin
            p = 2 * lim - p - s;
            d = -1;
         end
      end else begin
         if (s <= p) p = p - s;
         else begin
            p = s - p;
            d = 1;
         end
      end
   endfunction

   function automatic flat_t pack(input int a[N]);
      flat_t r;
      for (int i = 0; i < N; i++) r[i*CW +: CW] = CW'(a[i]);
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mx[i] = int'(INIT_X[i]);
         my[i] = int'(INIT_Y[i]);
         dx[i] = 1;
         dy[i] = 1;
      end
      ovr_exp = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input int spd, input bit [N-1:0] pz, input bit ovr);
      flat_t ox, oy;
      ox = pack(mx);
      oy = pack(my);
      for (int i = 0; i < N; i++) begin
         if (!pz[i]) begin
            axis(mx[i], dx[i], int'(INIT_VX[i]), spd, XM);
            axis(my[i], dy[i], int'(INIT_VY[i]), spd, YM);
         end
      end
      sb.push_back('{x: pack(mx), y: pack(my)});
      if (ovr) ovr_exp = 1'b1;
      bus.speed       = spd[1:0];
      bus.frame_start = 1'b1;
      tick();
      for (int k = 0; k < N; k++) begin
         bus.frame_start = ovr && (k == 2);
         bus.pause       = pz[k];
         chk("busy_step", 64'(bus.busy), 64'd1);
         tick();
      end
      bus.frame_start = 1'b0;
      bus.pause       = 1'b0;
      chk("busy_commit", 64'(bus.busy), 64'd1);
      chk("done_early", 64'(bus.done), 64'd0);
      chk("hold_x", 64'(bus.pt_x), 64'(ox));
      chk("hold_y", 64'(bus.pt_y), 64'(oy));
      tick();
      chk("done_pulse", 64'(bus.done), 64'd1);
      chk("busy_clear", 64'(bus.busy), 64'd0);
      chk("overrun", 64'(bus.overrun), 64'(ovr_exp));
      tick();
      chk("done_low", 64'(bus.done), 64'd0);
   endtask

   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("pt_x", 64'(bus.pt_x), 64'(mon_e.x));
            chk("pt_y", 64'(bus.pt_y), 64'(mon_e.y));
         end
      end
   end

   initial begin
      bit [N-1:0] pz;
      bus.frame_start = 1'b0;
      bus.pause       = 1'b0;
      bus.speed       = 2'd0;
      rst_n           = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      model_reset();
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_overrun", 64'(bus.overrun), 64'd0);
      chk("rst_x", 64'(bus.pt_x), 64'(pack(mx)));
      chk("rst_y", 64'(bus.pt_y), 64'(pack(my)));

      run_frame(0, '0, 1'b0);
      chk("pt0_x_103", 64'(bus.pt_x[CW-1:0]), 64'd103);
      chk("pt0_y_101", 64'(bus.pt_y[CW-1:0]), 64'd101);

      run_frame(1, '0, 1'b1);
      run_frame(3, '1, 1'b0);

      for (int f = 0; f < 80; f++) begin
         for (int i = 0; i < N; i++) pz[i] = ($urandom_range(0, 3) == 0);
         run_frame(int'($urandom_range(0, 3)), pz, $urandom_range(0, 7) == 0);
         repeat ($urandom_range(0, 2)) tick();
      end

      // Abort a frame at idx 2 with reset.
      bus.speed       = 2'd1;
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      model_reset();
      chk("mid_rst_busy", 64'(bus.busy), 64'd0);
      chk("mid_rst_overrun", 64'(bus.overrun), 64'd0);
      chk("mid_rst_x", 64'(bus.pt_x), 64'(pack(mx)));
      chk("mid_rst_y", 64'(bus.pt_y), 64'(pack(my)));
      tick();
      chk("mid_rst_done", 64'(bus.done), 64'd0);
      run_frame(2, '0, 1'b0);

      tick();
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/worley_point_sequencer.md
Name: worley_point_sequencer

Overview:
Owns the Worley feature-point set consumed by the noise datapath and advances it once per video frame. On a frame-start pulse (vblank entry) it steps each point through a shadow register file, one point per cycle, reflecting points off the screen edges. It then commits the shadow file to the active outputs in a single cycle, so the datapath never sees a half-updated set. It replaces ad-hoc time-derived point arithmetic with bounded, bouncing motion.

Parameters:
NUM_POINTS, 4, number of feature points (2..8)
COORD_W, 10, coordinate width, unsigned
X_MAX, 639, largest legal x coordinate
Y_MAX, 479, largest legal y coordinate
VEL_W, 4, velocity magnitude width, unsigned

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
frame_start  in  1  one-cycle pulse at vblank entry
pause  in  1  when 1, a frame update leaves positions and directions unchanged
speed  in  2  step shift: step = magnitude << speed
pt_x  out  NUM_POINTS*COORD_W  active x coordinates, point i at [i*COORD_W +: COORD_W]
pt_y  out  NUM_POINTS*COORD_W  active y coordinates, same packing
busy  out  1  high from the cycle after an accepted frame_start through COMMIT
done  out  1  one-cycle pulse after COMMIT
overrun  out  1  sticky; set when frame_start arrives while busy

Behaviour:
- Reset (rst_n=0 at a clk edge), from any state including mid-sequence:
  - FSM to IDLE; busy=0, done=0, overrun=0.
  - Active and shadow positions loaded from the package init tables.
  - All direction bits set to + (increasing).
  - Magnitudes loaded from the init tables.
- FSM states: IDLE, STEP, COMMIT, DONE.
  - IDLE: frame_start=1 -> STEP with idx=0. Shadow copies of the active file are already current.
  - STEP: one point per cycle; updates shadow x/y, direction and magnitude for point idx. When idx==NUM_POINTS-1 -> COMMIT, else idx+1.
  - COMMIT: active <= shadow for all points in one cycle -> DONE.
  - DONE: done=1 for this cycle -> IDLE.
- Latency:
  - frame_start at cycle 0; busy=1 in cycles 1..NUM_POINTS+1.
  - New pt_x/pt_y visible from cycle NUM_POINTS+2; done=1 in cycle NUM_POINTS+2.
- frame_start while busy is ignored and sets overrun. overrun clears only on reset.
- Per-axis arithmetic (one axis; x uses X_MAX, y uses Y_MAX):
  - step = mag << speed, computed at COORD_W+1 bits and clamped to MAX.
  - Direction +: if p+step <= MAX, new = p+step; else new = 2*MAX - p - step and dir flips to -.
  - Direction -: if step <= p, new = p-step; else new = step - p and dir flips to +.
  - Results always lie in 0..MAX. Exactly hitting 0 or MAX does not flip direction.
- pause=1 sampled at the STEP cycle: that point is unchanged. Sequencing, busy and done still occur.
- Magnitude 0 keeps the point stationary with no flip.

Optional Feature:
WORLEY_JITTER_EN
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4, reset value 8'hA5) advances every clk.
  - On each bounce of an axis, that axis magnitude is replaced by {LFSR[2:0]} | 1, giving a value in 1..7.
- Undefined: magnitudes stay at their init values forever and no LFSR is instantiated.

Decomposition:
- Package worley_pkg holds:
  - the FSM state enum;
  - init tables INIT_X, INIT_Y, INIT_VX, INIT_VY, each indexed by point (defaults x {100,300,500,100}, y {100,200,400,450}, vx {3,2,1,4}, vy {1,2,3,2});
  - the LFSR reset constant.
- Sub-module worley_axis_step: combinational single-axis reflect arithmetic.
  - Inputs: p, dir, mag, speed, MAX.
  - Outputs: new_p, new_dir, bounced.
  - Instantiated twice, for x and y.

Test Plan:
- Reset, point0 x=100 vx=3 speed=0, one frame_start -> pt_x[0]=103, done at cycle 6 (NUM_POINTS=4), busy high cycles 1..5.
- Upper bounce: x=637 dir + mag 3 -> 638, dir -; next frame -> 635.
- Lower bounce: y=1 dir - mag 3 -> 2, dir +; speed=2 with mag 3 and y=2 -> 14.
- frame_start pulsed again at cycle 3 -> ignored, overrun=1, result identical to the single-pulse case; overrun holds until reset.
- pause=1 across a frame -> pt_x/pt_y unchanged, done still pulses.
- Reset asserted during STEP (idx=2) -> busy=0, outputs equal the init tables, and the next frame_start completes normally.
